mem_bus_arbiter: RTL

//   Shares the processor's single external memory port between instruction fetch (imem, read-only)
//   and the load/store path (dmem, read/write). Registered FSM arbiter with fixed dmem priority
//   and an anti-starvation limit for fetch. Sits between the fetch/decode datapath and the

---
 rtl/mem_bus_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one external memory port between instruction fetch (imem, read
//   only) and the load/store path (dmem, read/write). Registered FSM: dmem has
//   fixed priority, and fetch is granted once dmem has won MAX_DMEM_STREAK
//   consecutive grants while fetch was waiting.
//
//   Optional feature: define MEM_ARB_TIMEOUT_EN to abort transfers that see no
//   mem_ready for TIMEOUT_CYCLES cycles. This also adds the timeout_err port.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   imem_addr/imem_re                 fetch request (level)
//   imem_data_out/imem_ready          fetched word (registered), done pulse
//   dmem_addr/dmem_data_in            load/store address, store data
//   dmem_re/dmem_wr                   load/store request (level)
//   dmem_data_out/dmem_ready          loaded word (registered), done pulse
//   mem_addr/mem_data_in/mem_re/mem_wr  registered external request
//   mem_data_out/mem_ready            external read data, completion
//   timeout_err                       abort pulse (MEM_ARB_TIMEOUT_EN only)
module mem_bus_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DMEM_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_re,
  output logic [DATA_W-1:0] imem_data_out,
  output logic              imem_ready,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_data_in,
  input  logic              dmem_re,
  input  logic              dmem_wr,
  output logic [DATA_W-1:0] dmem_data_out,
  output logic              dmem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_re,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data_out,
`ifdef MEM_ARB_TIMEOUT_EN
  input  logic              mem_ready,
  output logic              timeout_err
`else
  input  logic              mem_ready
`endif
);

  if (MAX_DMEM_STREAK < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mem_bus_arbiter: MAX_DMEM_STREAK and TIMEOUT_CYCLES must be >= 1");
  end

  localparam int SW = $clog2(MAX_DMEM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DMEM_STREAK);

  typedef enum logic [1:0] {IDLE, IXFER, DXFER} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic              mem_re_q, mem_re_d, mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] imem_data_q, imem_data_d, dmem_data_q, dmem_data_d;
  logic              imem_ready_q, imem_ready_d, dmem_ready_q, dmem_ready_d;
  logic              dreq, imem_win, done, abort;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
`endif

  assign dreq = dmem_re | dmem_wr;
  // Fetch wins only when dmem is idle or has used up its streak allowance.
  assign imem_win = imem_re & (~dreq | (streak_q == STREAK_MAX));
  assign done = (state_q != IDLE) & mem_ready;
`ifdef MEM_ARB_TIMEOUT_EN
  // cnt_q counts XFER cycles already spent; abort on the last allowed one.
  assign abort = (state_q != IDLE) & ~mem_ready & (cnt_q == CNT_LAST);
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    mem_re_d      = mem_re_q;
    mem_wr_d      = mem_wr_q;
    imem_data_d   = imem_data_q;
    dmem_data_d   = dmem_data_q;
    imem_ready_d  = 1'b0;
    dmem_ready_d  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (imem_win) begin
          state_d    = IXFER;
          mem_addr_d = imem_addr;
          mem_re_d   = 1'b1;
          mem_wr_d   = 1'b0;
          streak_d   = '0;
        end else if (dreq) begin
          state_d       = DXFER;
          mem_addr_d    = dmem_addr;
          mem_data_in_d = dmem_data_in;
          // Store wins when both load and store are requested.
          mem_wr_d      = dmem_wr;
          mem_re_d      = ~dmem_wr;
          if (!imem_re)                  streak_d = '0;
          else if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
        end
      end
      default: begin
        if (done || abort) begin
          state_d  = IDLE;
          mem_re_d = 1'b0;
          mem_wr_d = 1'b0;
          if (state_q == IXFER) imem_ready_d = 1'b1;
          else                  dmem_ready_d = 1'b1;
          // Reads capture data only on real completion; stores never touch it.
          if (done && state_q == IXFER)           imem_data_d = mem_data_out;
          if (done && state_q == DXFER && mem_re_q) dmem_data_d = mem_data_out;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d     = cnt_q + 1'b1;
        timeout_d = abort;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      streak_q      <= '0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_re_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      imem_data_q   <= '0;
      dmem_data_q   <= '0;
      imem_ready_q  <= 1'b0;
      dmem_ready_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_re_q      <= mem_re_d;
      mem_wr_q      <= mem_wr_d;
      imem_data_q   <= imem_data_d;
      dmem_data_q   <= dmem_data_d;
      imem_ready_q  <= imem_ready_d;
      dmem_ready_q  <= dmem_ready_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_data_in   = mem_data_in_q;
  assign mem_re        = mem_re_q;
  assign mem_wr        = mem_wr_q;
  assign imem_data_out = imem_data_q;
  assign dmem_data_out = dmem_data_q;
  assign imem_ready    = imem_ready_q;
  assign dmem_ready    = dmem_ready_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign timeout_err   = timeout_q;
`endif

endmodule
